// File: rtl/mips_decode_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_decode_exec_unit
// Brief    : Registered MIPS main control, ALU control and 32-bit ALU slice.
// Revision : 1.0 - initial release
// ============================================================================
module mips_decode_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [15:0]      imm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             regdst,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrc,
  output logic             jump,
  output logic [1:0]       aluop,
  output logic [3:0]       aluctl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken
);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [3:0] c_alu_and = 4'b0000;
  localparam logic [3:0] c_alu_or  = 4'b0001;
  localparam logic [3:0] c_alu_add = 4'b0010;
  localparam logic [3:0] c_alu_sub = 4'b0110;
  localparam logic [3:0] c_alu_slt = 4'b0111;
  localparam logic [3:0] c_alu_nor = 4'b1100;
  localparam logic [3:0] c_alu_xor = 4'b1101;

  // Control bundle order: regdst, beq, bne, memread, memwrite, memtoreg, regwrite, alusrc, jump
  logic [8:0]       w_ctrl;
  logic [1:0]       w_aluop;
  logic [3:0]       w_aluctl;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic             w_taken;

  logic [8:0]       r_ctrl;
  logic [1:0]       r_aluop;
  logic [3:0]       r_aluctl;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic             r_zero;
  logic             r_taken;

  always_comb begin
    w_ctrl  = 9'b0;
    w_aluop = 2'b00;
    case (opcode)
      c_op_rtype: begin w_ctrl = 9'b100000100; w_aluop = 2'b10; end
      c_op_lw:    w_ctrl = 9'b000101110;
      c_op_sw:    w_ctrl = 9'b000010010;
      c_op_beq:   begin w_ctrl = 9'b010000000; w_aluop = 2'b01; end
      c_op_bne:   begin w_ctrl = 9'b001000000; w_aluop = 2'b01; end
      c_op_addi:  w_ctrl = 9'b000000110;
      c_op_j:     w_ctrl = 9'b000000001;
      default:    w_ctrl = 9'b0;
    endcase
  end

  always_comb begin
    w_aluctl = c_alu_add;
    case (w_aluop)
      2'b01: w_aluctl = c_alu_sub;
      2'b10: begin
        case (funct)
          6'b100000: w_aluctl = c_alu_add;
          6'b100010: w_aluctl = c_alu_sub;
          6'b100100: w_aluctl = c_alu_and;
          6'b100101: w_aluctl = c_alu_or;
          6'b100110: w_aluctl = c_alu_xor;
          6'b100111: w_aluctl = c_alu_nor;
          6'b101010: w_aluctl = c_alu_slt;
          default:   w_aluctl = c_alu_and;
        endcase
      end
      default: w_aluctl = c_alu_add;
    endcase
  end

  assign w_opb = w_ctrl[1] ? {{(WIDTH-16){imm[15]}}, imm} : b;

  always_comb begin
    w_result = '0;
    case (w_aluctl)
      c_alu_and: w_result = a & w_opb;
      c_alu_or:  w_result = a | w_opb;
      c_alu_add: w_result = a + w_opb;
      c_alu_sub: w_result = a - w_opb;
      c_alu_slt: w_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(w_opb))};
      c_alu_nor: w_result = ~(a | w_opb);
      c_alu_xor: w_result = a ^ w_opb;
      default:   w_result = '0;
    endcase
  end

  assign w_zero  = (w_result == '0);
  assign w_taken = (w_ctrl[7] & w_zero) | (w_ctrl[6] & ~w_zero);

  // A bubble (in_valid low) clears the bank exactly like reset does.
  always_ff @(posedge clk) begin
    if (rst || !in_valid) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_aluop  <= '0;
      r_aluctl <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_taken  <= 1'b0;
    end else begin
      r_valid  <= 1'b1;
      r_ctrl   <= w_ctrl;
      r_aluop  <= w_aluop;
      r_aluctl <= w_aluctl;
      r_result <= w_result;
      r_zero   <= w_zero;
      r_taken  <= w_taken;
    end
  end

  assign out_valid    = r_valid;
  assign regdst       = r_ctrl[8];
  assign branch_eq    = r_ctrl[7];
  assign branch_ne    = r_ctrl[6];
  assign memread      = r_ctrl[5];
  assign memwrite     = r_ctrl[4];
  assign memtoreg     = r_ctrl[3];
  assign regwrite     = r_ctrl[2];
  assign alusrc       = r_ctrl[1];
  assign jump         = r_ctrl[0];
  assign aluop        = r_aluop;
  assign aluctl       = r_aluctl;
  assign result       = r_result;
  assign zero         = r_zero;
  assign branch_taken = r_taken;

endmodule
`default_nettype wire

// File: tb/tb_mips_decode_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_decode_exec_unit
// Brief    : Scoreboard bench for the registered decode/execute slice.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_decode_exec_unit;

  typedef struct packed {
    logic        valid;
    logic [8:0]  ctrl;
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic [31:0] result;
    logic        zero;
    logic        taken;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid, regdst, branch_eq, branch_ne, memread, memwrite;
  logic        memtoreg, regwrite, alusrc, jump, zero, branch_taken;
  logic [1:0]  aluop;
  logic [3:0]  aluctl;
  logic [31:0] result;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t r_sb[$];

  always #5 clk = ~clk;

  mips_decode_exec_unit #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .funct(funct),
    .imm(imm), .a(a), .b(b), .out_valid(out_valid), .regdst(regdst),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrc(alusrc), .jump(jump), .aluop(aluop), .aluctl(aluctl),
    .result(result), .zero(zero), .branch_taken(branch_taken)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: writes the expected architectural outcome of one instruction.
  function automatic exp_t model(input logic r, input logic v, input logic [5:0] op,
                                 input logic [5:0] fn, input logic [15:0] im,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [31:0] opb;
    e = '0;
    if (r || !v) return e;
    e.valid = 1'b1;
    unique case (op)
      6'b000000: begin e.ctrl = 9'b100000100; e.aluop = 2'd2; end
      6'b100011: e.ctrl = 9'b000101110;
      6'b101011: e.ctrl = 9'b000010010;
      6'b000100: begin e.ctrl = 9'b010000000; e.aluop = 2'd1; end
      6'b000101: begin e.ctrl = 9'b001000000; e.aluop = 2'd1; end
      6'b001000: e.ctrl = 9'b000000110;
      6'b000010: e.ctrl = 9'b000000001;
      default:   e.ctrl = 9'b0;
    endcase
    opb = e.ctrl[1] ? 32'($signed(im)) : y;
    if (e.aluop == 2'd2) begin
      case (fn)
        6'h20:   begin e.aluctl = 4'h2; e.result = x + opb; end
        6'h22:   begin e.aluctl = 4'h6; e.result = x - opb; end
        6'h24:   begin e.aluctl = 4'h0; e.result = x & opb; end
        6'h25:   begin e.aluctl = 4'h1; e.result = x | opb; end
        6'h26:   begin e.aluctl = 4'hD; e.result = x ^ opb; end
        6'h27:   begin e.aluctl = 4'hC; e.result = ~(x | opb); end
        6'h2A:   begin e.aluctl = 4'h7; e.result = ($signed(x) < $signed(opb)) ? 32'd1 : 32'd0; end
        default: begin e.aluctl = 4'h0; e.result = x & opb; end
      endcase
    end else if (e.aluop == 2'd1) begin
      e.aluctl = 4'h6;
      e.result = x - opb;
    end else begin
      e.aluctl = 4'h2;
      e.result = x + opb;
    end
    e.zero  = (e.result == 32'd0);
    e.taken = (e.ctrl[7] && e.zero) || (e.ctrl[6] && !e.zero);
    return e;
  endfunction

  task automatic step(input logic r, input logic v, input logic [5:0] op,
                      input logic [5:0] fn, input logic [15:0] im,
                      input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; opcode = op; funct = fn; imm = im; a = x; b = y;
    r_sb.push_back(model(r, v, op, fn, im, x, y));
    @(posedge clk);
    #1;
    if (r_sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = r_sb.pop_front();
      chk("out_valid", 32'(out_valid), 32'(e.valid));
      chk("ctrl", 32'({regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
                       regwrite, alusrc, jump}), 32'(e.ctrl));
      chk("aluop", 32'(aluop), 32'(e.aluop));
      chk("aluctl", 32'(aluctl), 32'(e.aluctl));
      chk("result", result, e.result);
      chk("zero", 32'(zero), 32'(e.zero));
      chk("branch_taken", 32'(branch_taken), 32'(e.taken));
    end
  endtask

  initial begin
    logic [5:0] fns [8];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h3F};
    rst = 1'b1; in_valid = 1'b1; opcode = '0; funct = '0; imm = '0; a = '0; b = '0;

    step(1'b1, 1'b1, 6'h00, 6'h20, 16'h1234, 32'hDEADBEEF, 32'h12345678);
    step(1'b1, 1'b1, 6'h23, 6'h00, 16'hFFFF, 32'hFFFFFFFF, 32'h1);
    step(1'b0, 1'b1, 6'h00, 6'h20, 16'h0, 32'h3, 32'h4);

    foreach (fns[i]) step(1'b0, 1'b1, 6'h00, fns[i], 16'h0, 32'h0000000F, 32'h000000F0);
    step(1'b0, 1'b1, 6'h00, 6'h2A, 16'h0, 32'hFFFFFFFF, 32'h1);
    step(1'b0, 1'b1, 6'h00, 6'h2A, 16'h0, 32'h1, 32'hFFFFFFFF);
    step(1'b0, 1'b1, 6'h00, 6'h20, 16'h0, 32'hFFFFFFFF, 32'h1);

    step(1'b0, 1'b1, 6'h23, 6'h00, 16'hFFFC, 32'h100, 32'h0);
    step(1'b0, 1'b1, 6'h2B, 6'h00, 16'hFFFC, 32'h100, 32'h77);
    step(1'b0, 1'b1, 6'h08, 6'h00, 16'h8000, 32'h100, 32'h0);
    step(1'b0, 1'b1, 6'h08, 6'h00, 16'h7FFF, 32'h1, 32'h0);

    step(1'b0, 1'b1, 6'h04, 6'h00, 16'h0, 32'd5, 32'd5);
    step(1'b0, 1'b1, 6'h05, 6'h00, 16'h0, 32'd5, 32'd5);
    step(1'b0, 1'b1, 6'h05, 6'h00, 16'h0, 32'd5, 32'd6);
    step(1'b0, 1'b1, 6'h04, 6'h00, 16'h0, 32'd5, 32'd6);

    step(1'b0, 1'b1, 6'h02, 6'h20, 16'h0040, 32'h10, 32'h20);
    step(1'b0, 1'b1, 6'h3F, 6'h22, 16'h0, 32'h10, 32'h20);
    step(1'b0, 1'b0, 6'h00, 6'h20, 16'h0, 32'h1, 32'h2);
    step(1'b1, 1'b1, 6'h00, 6'h20, 16'h0, 32'h1, 32'h2);
    step(1'b0, 1'b1, 6'h00, 6'h22, 16'h0, 32'h9, 32'h9);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 7))
        0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2B; 3: op = 6'h04;
        4: op = 6'h05; 5: op = 6'h08; 6: op = 6'h02; default: op = 6'($urandom);
      endcase
      step(1'b0, 1'($urandom_range(0, 9) != 0), op, fns[$urandom_range(0, 7)],
           16'($urandom), $urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
